btn_updown_counter: RTL and testbench
=====================================

// Module: btn_updown_counter
// PURPOSE
//  Debounced two-button up/down modulo counter with hold-to-repeat, feeding the LED/7-seg display path.
//  Each button passes through a 2-flop synchroniser and its own debounce/auto-repeat FSM; the accepted
//  steps drive one counter in [0, MAX] with selectable wrap or saturate. Wrap/limit events are flagged for the display/beeper.
// PARAMETERS
//  WIDTH          7    counter width; must satisfy MAX < 2**WIDTH
//  MAX            99   terminal count; range is 0..MAX
//  WRAP           1    1: wrap MAX<->0; 0: saturate at 0 and MAX
//  DB_CYCLES      20   consecutive stable synchronised samples to accept a press/release (>=1)
//  REPEAT_DELAY   500  cycles held after accept before first auto-repeat step; 0 disables repeat
//  REPEAT_PERIOD  100  cycles between subsequent auto-repeat steps (>=1)
//  CNT_W          clog2 width of internal timers, sized for max(DB_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  btn_up     in   1      raw increment button, asynchronous, active-high
//  btn_dn     in   1      raw decrement button, asynchronous, active-high
//  clr        in   1      synchronous clear of num, active-high
//  num        out  WIDTH  current count, registered
//  step_up    out  1      1-cycle pulse: accepted up step (press or repeat)
//  step_dn    out  1      1-cycle pulse: accepted down step
//  wrap_evt   out  1      1-cycle pulse, registered with num: wrapped (WRAP=1) or hit limit while stepping (WRAP=0)
// BEHAVIOUR
//  Reset: num=0, step_up=step_dn=wrap_evt=0, both FSMs IDLE, sync flops and timers 0. Async assert, sync release.
//  Synchroniser: s = 2-flop copy of raw button; all FSM decisions use s only.
//  Per-button FSM (identical for up/dn), timer t:
//   IDLE:   s=1 -> PRESS, t=1. Else stay.
//   PRESS:  s=0 -> IDLE. s=1 and t==DB_CYCLES-1 -> HELD, t=0, pulse step. Else t++.
//           (DB_CYCLES=1: IDLE->PRESS then accept on next sample; accept = DB_CYCLES consecutive s=1)
//   HELD:   s=0 -> RELEASE, t=1. REPEAT_DELAY!=0 and t==REPEAT_DELAY-1 -> REPEAT, t=0, pulse step. Else t++.
//   REPEAT: s=0 -> RELEASE, t=1. t==REPEAT_PERIOD-1 -> t=0, pulse step. Else t++.
//   RELEASE: s=1 -> HELD, t=0 (glitch during release restarts repeat delay, no step).
//            s=0 and t==DB_CYCLES-1 -> IDLE. Else t++.
//  Step pulses are registered FSM outputs, exactly 1 cycle; one pulse per press plus one per repeat.
//  Latency: num updates on the edge after step pulse is high; raw press to num change = 2+DB_CYCLES+1 edges.
//  Counter update, priority high->low each cycle:
//   1. clr=1: num<=0, wrap_evt<=0, steps ignored that cycle.
//   2. step_up & step_dn same cycle: cancel, num holds, wrap_evt=0.
//   3. step_up: num==MAX ? (WRAP ? 0 : MAX) with wrap_evt=1 : num+1.
//   4. step_dn: num==0 ? (WRAP ? MAX : 0) with wrap_evt=1 : num-1.
//   5. else hold, wrap_evt=0.
//  Arithmetic is WIDTH-bit unsigned; num never leaves [0,MAX]. Out-of-range num impossible by construction;
//  if num>MAX ever observed (e.g. SEU), next step_up loads 0.
//  Both buttons held: each FSM runs independently; coincident pulses cancel per rule 2.
//  rst mid-press: all state cleared; a button still held after reset must pass full PRESS debounce again.
//  clr has no effect on the FSMs; a held button continues repeating after clr.
// TESTING  (bench params: MAX=9, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Clean press btn_up 20 cycles from num=0 -> one step_up, num=1 at edge 2+4+1 after press; release -> IDLE, no more steps.
//  Bounce: btn_up toggles every 2 cycles for 12 cycles, then steady 1 -> exactly one step, num+1, only after steady run.
//  Hold btn_up 40 cycles from num=0 -> step at accept, repeats at +10,+13,+16,... ; num wraps 9->0 with wrap_evt=1 that cycle.
//  WRAP=0: num=0, press btn_dn -> num stays 0, wrap_evt=1; num=9, press btn_up -> num stays 9, wrap_evt=1.
//  Both buttons pressed on same cycle, num=5 -> simultaneous pulses cancel, num stays 5; clr during step -> num=0.
//  Assert rst during HELD with btn_up still high -> num=0 immediately; after release, new step only after 4 stable samples.

Source files
------------

// File: rtl/btn_updown_counter.sv
// Two-button up/down modulo counter: each raw button is synchronised, debounced and
// auto-repeated by its own FSM, and the accepted steps drive a wrap-or-saturate counter.
module btn_updown_counter #(
  parameter int WIDTH         = 7,
  parameter int MAX           = 99,
  parameter int WRAP          = 1,
  parameter int DB_CYCLES     = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int CNT_W         = $clog2(((DB_CYCLES > REPEAT_DELAY)
                                  ? ((DB_CYCLES > REPEAT_PERIOD) ? DB_CYCLES : REPEAT_PERIOD)
                                  : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD)) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             clr,
  output logic [WIDTH-1:0] num,
  output logic             step_up,
  output logic             step_dn,
  output logic             wrap_evt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_REPEAT,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_EN  = (REPEAT_DELAY != 0);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

  logic [1:0] btn_raw;
  logic [1:0] step_p2;

  assign btn_raw = {btn_dn, btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             sync_p0;
    logic             sync_p1;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_nxt;
    logic             step_nxt;
    logic             step_q;

    // stage p0/p1: synchroniser; p2: FSM state and registered step pulse
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        state   <= S_IDLE;
        tmr     <= '0;
        step_q  <= 1'b0;
      end else begin
        sync_p0 <= btn_raw[g];
        sync_p1 <= sync_p0;
        state   <= state_nxt;
        tmr     <= tmr_nxt;
        step_q  <= step_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      step_nxt  = 1'b0;
      case (state)
        S_IDLE: begin
          if (sync_p1) begin
            state_nxt = S_PRESS;
            tmr_nxt   = CNT_W'(1);
          end
        end
        // >= keeps DB_CYCLES=1 accepting on the sample after entry
        S_PRESS: begin
          if (!sync_p1) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
          end else if (tmr >= DB_LAST) begin
            state_nxt = S_HELD;
            tmr_nxt   = '0;
            step_nxt  = 1'b1;
          end else begin
            tmr_nxt   = tmr + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!sync_p1) begin
            state_nxt = S_RELEASE;
            tmr_nxt   = CNT_W'(1);
          end else if (RPT_EN && tmr >= RD_LAST) begin
            state_nxt = S_REPEAT;
            tmr_nxt   = '0;
            step_nxt  = 1'b1;
          end else if (RPT_EN) begin
            tmr_nxt   = tmr + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!sync_p1) begin
            state_nxt = S_RELEASE;
            tmr_nxt   = CNT_W'(1);
          end else if (tmr >= RP_LAST) begin
            tmr_nxt   = '0;
            step_nxt  = 1'b1;
          end else begin
            tmr_nxt   = tmr + CNT_W'(1);
          end
        end
        // a glitch back to 1 returns to HELD and restarts the repeat delay silently
        S_RELEASE: begin
          if (sync_p1) begin
            state_nxt = S_HELD;
            tmr_nxt   = '0;
          end else if (tmr >= DB_LAST) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
          end else begin
            tmr_nxt   = tmr + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end
      endcase
    end

    assign step_p2[g] = step_q;
  end

  assign step_up = step_p2[0];
  assign step_dn = step_p2[1];

  // Returns {wrap_evt, next count}; an out-of-range count recovers to 0 on the next up step.
  function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur,
                                                input logic up, input logic dn);
    logic [WIDTH-1:0] nxt;
    logic             wev;
    nxt = cur;
    wev = 1'b0;
    if (up && !dn) begin
      if (cur > MAX_V) begin
        nxt = '0;
      end else if (cur == MAX_V) begin
        nxt = (WRAP != 0) ? '0 : MAX_V;
        wev = 1'b1;
      end else begin
        nxt = cur + WIDTH'(1);
      end
    end else if (dn && !up) begin
      if (cur == '0) begin
        nxt = (WRAP != 0) ? MAX_V : '0;
        wev = 1'b1;
      end else begin
        nxt = cur - WIDTH'(1);
      end
    end
    return {wev, nxt};
  endfunction

  // stage p3: counter and wrap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num      <= '0;
      wrap_evt <= 1'b0;
    end else if (clr) begin
      num      <= '0;
      wrap_evt <= 1'b0;
    end else begin
      {wrap_evt, num} <= next_count(num, step_up, step_dn);
    end
  end

endmodule

// File: tb/tb_btn_updown_counter.sv
// Bench for btn_updown_counter: a wrapping and a saturating instance share stimulus and
// are checked every cycle against a run-length model of the button rules.
module tb_btn_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic clr = 1'b0;

  logic [W-1:0] num_w, num_s;
  logic su_w, sd_w, we_w, su_s, sd_s, we_s;

  int n_cmp = 0;
  int n_bad = 0;

  btn_updown_counter #(.WIDTH(W), .MAX(MAXV), .WRAP(1), .DB_CYCLES(DB),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
    .num(num_w), .step_up(su_w), .step_dn(sd_w), .wrap_evt(we_w));

  btn_updown_counter #(.WIDTH(W), .MAX(MAXV), .WRAP(0), .DB_CYCLES(DB),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_s (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
    .num(num_s), .step_up(su_s), .step_dn(sd_s), .wrap_evt(we_s));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model: per button, run lengths of the synchronised level plus time held since
  // acceptance; counter per instance (index 0 wraps, index 1 saturates).
  bit sh0[2], sh1[2], pressed[2];
  int run1[2], run0[2], age[2];
  bit m_su, m_sd;
  int m_num[2];
  bit m_wev[2];

  always @(posedge clk or posedge rst) begin : model
    bit st[2];
    bit s;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        sh0[b] = 0; sh1[b] = 0; pressed[b] = 0;
        run1[b] = 0; run0[b] = 0; age[b] = 0;
        m_num[b] = 0; m_wev[b] = 0;
      end
      m_su = 0; m_sd = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_wev[k] = 0;
        if (clr) m_num[k] = 0;
        else if (m_su && m_sd) m_num[k] = m_num[k];
        else if (m_su) begin
          if (m_num[k] == MAXV) begin
            m_num[k] = (k == 0) ? 0 : MAXV;
            m_wev[k] = 1;
          end else m_num[k] = m_num[k] + 1;
        end else if (m_sd) begin
          if (m_num[k] == 0) begin
            m_num[k] = (k == 0) ? MAXV : 0;
            m_wev[k] = 1;
          end else m_num[k] = m_num[k] - 1;
        end
      end
      for (int b = 0; b < 2; b++) begin
        s = sh1[b];
        st[b] = 0;
        if (!pressed[b]) begin
          if (s) begin
            run1[b]++;
            if (run1[b] == DB) begin
              pressed[b] = 1; st[b] = 1; age[b] = 0; run0[b] = 0;
            end
          end else run1[b] = 0;
        end else begin
          if (!s) begin
            run0[b]++;
            if (run0[b] == DB) begin
              pressed[b] = 0; run1[b] = 0; run0[b] = 0;
            end
          end else if (run0[b] > 0) begin
            run0[b] = 0; age[b] = 0;
          end else begin
            age[b]++;
            if (RD != 0 && age[b] >= RD && (age[b] - RD) % RP == 0) st[b] = 1;
          end
        end
      end
      m_su = st[0];
      m_sd = st[1];
      sh1[0] = sh0[0]; sh1[1] = sh0[1];
      sh0[0] = btn_up; sh0[1] = btn_dn;
    end
  end

  always @(negedge clk) begin
    chk("num_wrap", num_w, m_num[0]);
    chk("num_sat", num_s, m_num[1]);
    chk("wrap_evt_wrap", we_w, m_wev[0]);
    chk("wrap_evt_sat", we_s, m_wev[1]);
    chk("step_up_wrap", su_w, m_su);
    chk("step_dn_wrap", sd_w, m_sd);
    chk("step_up_sat", su_s, m_su);
    chk("step_dn_sat", sd_s, m_sd);
  end

  initial begin
    tick(3);
    chk("rst_num", num_w, 0);
    chk("rst_step_up", su_w, 0);
    chk("rst_wrap_evt", we_w, 0);
    rst = 0;
    tick(2);

    // clean press: pulse 6 edges after press, count 7 edges after
    btn_up = 1;
    tick(6);
    chk("press_pulse", su_w, 1);
    chk("press_num_before", num_w, 0);
    tick(1);
    chk("press_num_after", num_w, 1);
    tick(1);
    btn_up = 0;
    tick(12);
    chk("press_single", num_w, 1);

    // bounce: 2-cycle runs are rejected, steady run accepted once
    for (int i = 0; i < 6; i++) begin
      btn_up = ~btn_up;
      tick(2);
    end
    chk("bounce_none", num_w, 1);
    btn_up = 1;
    tick(8);
    btn_up = 0;
    tick(12);
    chk("bounce_one", num_w, 2);

    // hold 40 cycles: steps at 6,16,19,...,40; tenth step wraps / saturates
    clr = 1; tick(1); clr = 0; tick(1);
    btn_up = 1;
    tick(40);
    btn_up = 0;
    tick(1);
    chk("hold_wrap_num", num_w, 0);
    chk("hold_wrap_evt", we_w, 1);
    chk("hold_sat_num", num_s, MAXV);
    chk("hold_sat_evt", we_s, 1);
    tick(12);

    // down from 0
    clr = 1; tick(1); clr = 0; tick(1);
    btn_dn = 1;
    tick(7);
    chk("dn_wrap_num", num_w, MAXV);
    chk("dn_wrap_evt", we_w, 1);
    chk("dn_sat_num", num_s, 0);
    chk("dn_sat_evt", we_s, 1);
    tick(1);
    btn_dn = 0;
    tick(12);

    // reach 5, then both buttons together cancel
    clr = 1; tick(1); clr = 0; tick(1);
    for (int i = 0; i < 5; i++) begin
      btn_up = 1; tick(8); btn_up = 0; tick(10);
    end
    chk("five_num", num_w, 5);
    btn_up = 1; btn_dn = 1;
    tick(6);
    chk("both_su", su_w, 1);
    chk("both_sd", sd_w, 1);
    tick(1);
    chk("both_cancel_w", num_w, 5);
    chk("both_cancel_s", num_s, 5);
    tick(1);
    btn_up = 0; btn_dn = 0;
    tick(12);

    // clr coinciding with a step pulse wins
    btn_up = 1;
    tick(6);
    clr = 1;
    tick(1);
    clr = 0;
    chk("clr_over_step", num_w, 0);
    btn_up = 0;
    tick(12);

    // reset while held: full debounce again after release of reset
    btn_up = 1;
    tick(9);
    chk("held_num", num_w, 1);
    rst = 1;
    #1;
    chk("rst_held_num", num_w, 0);
    tick(2);
    rst = 0;
    tick(5);
    chk("rst_redebounce_wait", num_w, 0);
    tick(1);
    chk("rst_redebounce_pulse", su_w, 1);
    tick(1);
    chk("rst_redebounce_num", num_w, 1);
    btn_up = 0;
    tick(12);

    // randomized phase
    for (int i = 0; i < 160; i++) begin
      int dur;
      btn_up = 1'($urandom_range(0, 1));
      btn_dn = 1'($urandom_range(0, 3) == 0);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
      for (int c = 0; c < dur; c++) begin
        clr = 1'($urandom_range(0, 49) == 0);
        tick(1);
      end
      clr = 0;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1; tick(2); rst = 0;
      end
    end
    btn_up = 0; btn_dn = 0;
    tick(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
